// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns the cache's level-sensitive read/write requests into a
// single-outstanding req/ack transaction on the external memory port.
// Completion is signalled by a one-cycle pulse: rd_valid_o for a read,
// wr_done_o for a write. A timeout aborts the transaction and pulses err_o.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   read_req_i       cache read request (level)
//   write_req_i      cache write request (level, wins over read)
//   addr_i, wdata_i  request address / write data
//   rdata_o          last read data returned
//   rd_valid_o       one-cycle pulse, rdata_o valid
//   wr_done_o        one-cycle pulse, write completed (or accepted if posted)
//   busy_o           a new request cannot be accepted this cycle
//   err_o            one-cycle pulse on timeout abort
//   mem_req_o        memory request, held until mem_ack_i or timeout
//   mem_we_o         1 = write, 0 = read
//   mem_addr_o       registered address
//   mem_wdata_o      registered write data
//   mem_ack_i        memory completion, only looked at while mem_req_o=1
//   mem_rdata_i      read data, valid in the mem_ack_i cycle
//
// Build option: MEM_WBUF_EN makes writes posted through a 1-entry buffer.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req_i,
    input  logic              write_req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rd_valid_o,
    output logic              wr_done_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = 8;
    // Last cycle in which an ack is still accepted; no ack here aborts.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_done_q, wr_done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            wr_done_q   <= wr_done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        rd_valid_d  = 1'b0;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (write_req_i) begin
                    state_d     = WR;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_i;
                    mem_wdata_d = wdata_i;
`ifdef MEM_WBUF_EN
                    // Posted: acknowledge as soon as the buffer holds the write.
                    wr_done_d   = 1'b1;
`endif
                end else if (read_req_i) begin
                    state_d    = RD;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_i;
                end
            end
            RD, WR: begin
                // An ack in the last allowed cycle still completes normally.
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == RD) begin
                        rdata_d    = mem_rdata_i;
                        rd_valid_d = 1'b1;
                    end else begin
`ifdef MEM_WBUF_EN
                        state_d   = IDLE;
`else
                        wr_done_d = 1'b1;
`endif
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef MEM_WBUF_EN
    logic drain_q;

    // Marks a buffered write draining on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_q <= 1'b0;
        end else begin
            drain_q <= (state_d == WR);
        end
    end

    // While draining, only a new request sees the controller as busy.
    assign busy_o = busy_q & ~(drain_q & ~(read_req_i | write_req_i));
`else
    assign busy_o = busy_q;
`endif

    assign rdata_o     = rdata_q;
    assign rd_valid_o  = rd_valid_q;
    assign wr_done_o   = wr_done_q;
    assign err_o       = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Main-memory bus controller sitting directly downstream of the cache control FSM. It converts the cache's level-sensitive read/write requests into a single-outstanding req/ack transaction on the external memory port. It returns read data with a one-cycle valid pulse and reports busy and timeout status back to the cache.

## Interface
- ADDR_W, default 10: word address width.
- DATA_W, default 32: data word width.
- TIMEOUT, default 15: max cycles mem_req may wait for mem_ack (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- read_req  in  1  cache read request (level).
- write_req  in  1  cache write request (level).
- addr  in  ADDR_W  word address from core/cache.
- wdata  in  DATA_W  write data from core.
- rdata  out  DATA_W  read data returned to cache data array.
- rd_valid  out  1  one-cycle pulse, rdata valid.
- wr_done  out  1  one-cycle pulse, write accepted/completed.
- busy  out  1  controller cannot accept a new request this cycle.
- err  out  1  one-cycle pulse on timeout abort.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid in mem_ack cycle.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: write_req=1 -> capture addr/wdata, go WR. Else read_req=1 -> capture addr, go RD. Write has priority when both are high; the read stays pending because the requester holds it.
- RD/WR: mem_req=1, mem_we=(state==WR). On mem_ack: RD latches mem_rdata into rdata; go RESP.
- RESP: pulse rd_valid (after RD) or wr_done (after WR); go IDLE.
- Timeout: 8-bit counter cleared on entry to RD/WR, incremented each cycle without ack. Counter reaching TIMEOUT with no ack -> drop mem_req, pulse err next cycle, rdata unchanged, no rd_valid/wr_done, go IDLE.
- busy = (state != IDLE).
- Requests are level-sensitive. A request still high in the IDLE cycle after RESP starts a new transaction, so the requester deasserts on rd_valid/wr_done.
- mem_ack outside RD/WR is ignored.

## Timing
- Reset values: rdata=0, rd_valid=0, wr_done=0, busy=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; state IDLE; counter 0.
- Request sampled in IDLE at cycle 0 -> mem_req high from cycle 1.
- mem_ack in cycle k (k>=1) -> rd_valid/wr_done high in cycle k+1 -> IDLE in k+2. Minimum round trip is 3 cycles, 2 of them busy.
- mem_ack coincident with timeout cycle: ack wins, normal completion.
- rst mid-transaction: immediate return to IDLE, mem_req dropped asynchronously, no completion pulse.

## Configuration
- MEM_WBUF_EN defined: WR is posted. In IDLE, write_req captures into a 1-entry write buffer, wr_done pulses the next cycle, and busy stays 0 while the buffer drains on the bus.
  - A second write or any read while the buffer is occupied sees busy=1 until the drain completes.
  - A drain timeout pulses err only.
- MEM_WBUF_EN undefined: writes are non-posted, exactly as in Operation.

## Test plan
- Read, ack after 3 cycles: read_req at c0, addr=0x05, mem_rdata=0xDEADBEEF with ack at c4 -> mem_req c1..c4, mem_addr=0x05, rd_valid and rdata=0xDEADBEEF at c5, busy=0 at c6.
- Simultaneous read_req and write_req, addr=0x10, wdata=0x1234: WR first (mem_we=1, mem_wdata=0x1234), wr_done. Then RD on the next IDLE with the held read_req.
- Timeout, TIMEOUT=4, no ack: mem_req high exactly 4 cycles, err pulse once, no rd_valid, rdata keeps old value.
- rst pulse mid-RD: mem_req=0 and busy=0 asynchronously. A subsequent ack is ignored and no rd_valid follows.
- Ack on the same cycle as the timeout limit: rd_valid pulses, err stays 0.
- With MEM_WBUF_EN, write then read back-to-back: wr_done at c1, read waits (busy=1) until the drain ack, then a normal read completes.
